// File: rtl/sharpen_frame_ctrl.sv
// Frame-synchronous control for the Laplacian sharpen stage: shadowed config, pixel
// coordinates, border flag, bypass select, frame counter and geometry status.
// Optional SHARPEN_CTRL_BORDER_BYPASS_EN: also force bypass on border pixels.
module sharpen_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_clken,
  input  logic        cfg_req,
  input  logic        cfg_en,
  input  logic [1:0]  cfg_strength,
  output logic        cfg_busy,
  output logic        cfg_ack,
  output logic        sharpen_en,
  output logic [1:0]  strength,
  output logic        bypass_sel,
  output logic        pos_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        edge_flag,
  output logic [7:0]  frame_cnt,
  input  logic        err_clr,
  output logic        err_geom,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_FRAME  = 2'd1,
    S_VBLANK = 2'd2
  } state_t;

  localparam logic [10:0] LP_W      = 11'(IMG_W);
  localparam logic [10:0] LP_H      = 11'(IMG_H);
  localparam logic [10:0] LP_W_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] LP_H_LAST = 11'(IMG_H - 1);
  localparam logic [10:0] LP_SAT    = 11'h7FF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vsync_d;
  logic        r_href_d;
  logic        r_busy;
  logic        r_ack;
  logic        r_pend_en;
  logic [1:0]  r_pend_str;
  logic        r_en;
  logic [1:0]  r_str;
  logic [10:0] r_x_cnt;
  logic [10:0] r_y_cnt;
  logic        r_valid;
  logic [10:0] r_pix_x;
  logic [10:0] r_pix_y;
  logic        r_edge;
  logic [7:0]  r_frame_cnt;
  logic        r_err;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_fall;
  logic w_pix;
  logic w_frame_start;
  logic w_frame_end;
  logic w_accept;
  logic w_apply;
  logic w_edge;
  logic w_x_bad;
  logic w_y_bad;
  logic w_bypass;

  // The vsync copy resets high so a vsync already high when reset releases is not
  // mistaken for a frame start; the remainder of that frame stays in S_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b1;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= in_vsync;
      r_href_d  <= in_href;
    end
  end

  assign w_vs_rise     = in_vsync & ~r_vsync_d;
  assign w_vs_fall     = ~in_vsync & r_vsync_d;
  assign w_href_fall   = ~in_href & r_href_d;
  assign w_pix         = in_href & in_clken;
  assign w_frame_start = w_vs_rise & (r_state != S_FRAME);
  assign w_frame_end   = w_vs_fall & (r_state == S_FRAME);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bypass    = (r_state == S_WAIT) | ~r_en;
    case (r_state)
      S_WAIT:   if (w_vs_rise) w_state_nxt = S_FRAME;
      S_FRAME:  if (w_vs_fall) w_state_nxt = S_VBLANK;
      S_VBLANK: if (w_vs_rise) w_state_nxt = S_FRAME;
      default:  w_state_nxt = S_WAIT;
    endcase
`ifdef SHARPEN_CTRL_BORDER_BYPASS_EN
    w_bypass = w_bypass | r_edge;
`endif
  end

  // Host handshake: a cycle with cfg_req=1 while cfg_busy=0 is an accept; cfg_busy
  // then stays high until the next frame start, where the pending value moves into
  // the shadow registers together with a single-cycle cfg_ack. Requests seen while
  // cfg_busy=1 are dropped, so the host must watch cfg_busy/cfg_ack to re-request.
  assign w_accept = cfg_req & ~r_busy;
  assign w_apply  = w_frame_start & r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_pend_en  <= 1'b0;
      r_pend_str <= 2'd0;
      r_en       <= 1'b0;
      r_str      <= 2'd0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_en   <= r_pend_en;
        r_str  <= r_pend_str;
        r_busy <= 1'b0;
      end else if (w_accept) begin
        r_pend_en  <= cfg_en;
        r_pend_str <= cfg_strength;
        r_busy     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      if (w_href_fall)                   r_x_cnt <= '0;
      else if (w_pix && r_x_cnt != LP_SAT) r_x_cnt <= r_x_cnt + 11'd1;
      if (w_frame_start)                       r_y_cnt <= '0;
      else if (w_href_fall && r_y_cnt != LP_SAT) r_y_cnt <= r_y_cnt + 11'd1;
    end
  end

  assign w_edge = (r_x_cnt == 11'd0) | (r_x_cnt == LP_W_LAST) |
                  (r_y_cnt == 11'd0) | (r_y_cnt == LP_H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pix_x <= '0;
      r_pix_y <= '0;
      r_edge  <= 1'b0;
    end else begin
      r_valid <= w_pix;
      if (w_pix) begin
        r_pix_x <= r_x_cnt;
        r_pix_y <= r_y_cnt;
        r_edge  <= w_edge;
      end
    end
  end

  // Geometry is only trusted once a full frame start has been seen.
  assign w_x_bad = w_href_fall & (r_state != S_WAIT) & (r_x_cnt != LP_W);
  assign w_y_bad = w_frame_end & (r_y_cnt != LP_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      if (w_x_bad | w_y_bad) r_err <= 1'b1;
      else if (err_clr)      r_err <= 1'b0;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign cfg_busy   = r_busy;
  assign cfg_ack    = r_ack;
  assign sharpen_en = r_en;
  assign strength   = r_str;
  assign bypass_sel = w_bypass;
  assign pos_valid  = r_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign edge_flag  = r_edge;
  assign frame_cnt  = r_frame_cnt;
  assign err_geom   = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// Bench for sharpen_frame_ctrl with an 8x4 image: frame-level model plus literal pins.
module tb_sharpen_frame_ctrl;
  localparam int W = 8;
  localparam int H = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_vsync, in_href, in_clken, cfg_req, cfg_en, err_clr;
  logic [1:0]  cfg_strength;
  logic        cfg_busy, cfg_ack, sharpen_en, bypass_sel, pos_valid, edge_flag, err_geom;
  logic [1:0]  strength, dbg_state;
  logic [10:0] pix_x, pix_y;
  logic [7:0]  frame_cnt;

  sharpen_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_clken(in_clken),
    .cfg_req(cfg_req), .cfg_en(cfg_en), .cfg_strength(cfg_strength), .cfg_busy(cfg_busy),
    .cfg_ack(cfg_ack), .sharpen_en(sharpen_en), .strength(strength), .bypass_sel(bypass_sel),
    .pos_valid(pos_valid), .pix_x(pix_x), .pix_y(pix_y), .edge_flag(edge_flag),
    .frame_cnt(frame_cnt), .err_clr(err_clr), .err_geom(err_geom), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // what the driver is presenting this cycle
  int drv_x = 0, drv_y = 0, drv_last_len = 0, drv_lines = 0;

  // frame-level model, advanced on each clock edge
  logic [21:0] exp_q[$];
  bit          m_wait, m_in_frame, m_prev_vs, m_prev_href;
  bit          m_busy, m_ack, m_en, m_pend_en, m_err, m_valid;
  logic [1:0]  m_str, m_pend_str;
  logic [7:0]  m_fcnt;

  always @(posedge clk or negedge rst_n) begin : model
    bit rise, fall, hfall, start, was_wait, was_frame, was_busy, set_err;
    if (!rst_n) begin
      m_wait = 1; m_in_frame = 0; m_prev_vs = 1; m_prev_href = 0;
      m_busy = 0; m_ack = 0; m_en = 0; m_pend_en = 0; m_err = 0; m_valid = 0;
      m_str = 0; m_pend_str = 0; m_fcnt = 0;
      exp_q.delete();
    end else begin
      rise      = in_vsync && !m_prev_vs;
      fall      = !in_vsync && m_prev_vs;
      hfall     = !in_href && m_prev_href;
      was_wait  = m_wait;
      was_frame = m_in_frame;
      was_busy  = m_busy;
      start     = rise && !was_frame;
      if (start) begin m_wait = 0; m_in_frame = 1; end
      if (fall && was_frame) begin m_in_frame = 0; m_fcnt = m_fcnt + 8'd1; end
      m_ack = start && was_busy;
      if (m_ack) begin
        m_en = m_pend_en; m_str = m_pend_str; m_busy = 0;
      end else if (cfg_req && !was_busy) begin
        m_pend_en = cfg_en; m_pend_str = cfg_strength; m_busy = 1;
      end
      set_err = (hfall && !was_wait && drv_last_len != W) ||
                (fall && was_frame && drv_lines != H);
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
      m_valid = in_href && in_clken;
      if (m_valid) exp_q.push_back({11'(drv_y), 11'(drv_x)});
      m_prev_vs   = in_vsync;
      m_prev_href = in_href;
    end
  end

  // compare process plus capture of a few border-bypass samples
  bit capture = 0;
  bit ack_seen = 0;
  int byp_pin[4] = '{-1, -1, -1, -1};

  always @(negedge clk) begin : compare
    logic [21:0] e;
    int ex, ey;
    bit edge_e, byp_e;
    if (rst_n) begin
      check("pos_valid", int'(pos_valid), int'(m_valid));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          ex = int'(e[10:0]);
          ey = int'(e[21:11]);
          edge_e = (ex == 0) || (ex == W - 1) || (ey == 0) || (ey == H - 1);
          byp_e  = m_wait || !m_en;
`ifdef SHARPEN_CTRL_BORDER_BYPASS_EN
          byp_e  = byp_e || edge_e;
`endif
          check("pix_x", int'(pix_x), ex);
          check("pix_y", int'(pix_y), ey);
          check("edge_flag", int'(edge_flag), int'(edge_e));
          check("bypass_sel", int'(bypass_sel), int'(byp_e));
        end
      end
      check("sharpen_en", int'(sharpen_en), int'(m_en));
      check("strength", int'(strength), int'(m_str));
      check("cfg_busy", int'(cfg_busy), int'(m_busy));
      check("cfg_ack", int'(cfg_ack), int'(m_ack));
      check("frame_cnt", int'(frame_cnt), int'(m_fcnt));
      check("err_geom", int'(err_geom), int'(m_err));
      if (cfg_ack) ack_seen = 1;
      if (capture && pos_valid) begin
        if (pix_x == 11'd0 && pix_y == 11'd0) byp_pin[0] = int'(bypass_sel);
        if (pix_x == 11'd7 && pix_y == 11'd2) byp_pin[1] = int'(bypass_sel);
        if (pix_x == 11'd3 && pix_y == 11'd3) byp_pin[2] = int'(bypass_sel);
        if (pix_x == 11'd3 && pix_y == 11'd1) byp_pin[3] = int'(bypass_sel);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_line(input int len, input int y);
    in_href = 1'b1;
    for (int x = 0; x < len; x++) begin
      if (x == 4 && y == 2) begin
        in_clken = 1'b0;
        tick();
      end
      in_clken = 1'b1;
      drv_x = x;
      drv_y = y;
      tick();
    end
    in_href = 1'b0;
    in_clken = 1'b0;
    drv_last_len = len;
    drv_lines = y + 1;
    tick();
    tick();
  endtask

  task automatic drive_frame(input int short_line);
    in_vsync = 1'b1;
    tick();
    tick();
    for (int y = 0; y < H; y++) drive_line((y == short_line) ? W - 1 : W, y);
    in_vsync = 1'b0;
    repeat (3) tick();
  endtask

  task automatic cfg_request(input bit en, input logic [1:0] str);
    cfg_req = 1'b1;
    cfg_en = en;
    cfg_strength = str;
    tick();
    cfg_req = 1'b0;
    check("busy_after_req", int'(cfg_busy), 1);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_valid"}, int'(pos_valid), 0);
    check({tag, "_pix_x"}, int'(pix_x), 0);
    check({tag, "_pix_y"}, int'(pix_y), 0);
    check({tag, "_edge"}, int'(edge_flag), 0);
    check({tag, "_en"}, int'(sharpen_en), 0);
    check({tag, "_str"}, int'(strength), 0);
    check({tag, "_busy"}, int'(cfg_busy), 0);
    check({tag, "_ack"}, int'(cfg_ack), 0);
    check({tag, "_fcnt"}, int'(frame_cnt), 0);
    check({tag, "_err"}, int'(err_geom), 0);
    check({tag, "_bypass"}, int'(bypass_sel), 1);
  endtask

  initial begin
    in_vsync = 0; in_href = 0; in_clken = 0;
    cfg_req = 0; cfg_en = 0; cfg_strength = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (3) tick();

    // two clean frames
    drive_frame(-1);
    drive_frame(-1);
    check("two_frames_fcnt", int'(frame_cnt), 2);
    check("two_frames_err", int'(err_geom), 0);

    // config in vblank, second request while busy must be dropped
    cfg_request(1'b1, 2'd2);
    cfg_request(1'b1, 2'd3);
    capture = 1;
    drive_frame(-1);
    capture = 0;
    check("apply_en", int'(sharpen_en), 1);
    check("apply_str", int'(strength), 2);
    check("apply_busy", int'(cfg_busy), 0);
`ifdef SHARPEN_CTRL_BORDER_BYPASS_EN
    check("byp_0_0", byp_pin[0], 1);
    check("byp_7_2", byp_pin[1], 1);
    check("byp_3_3", byp_pin[2], 1);
`else
    check("byp_0_0", byp_pin[0], 0);
    check("byp_7_2", byp_pin[1], 0);
    check("byp_3_3", byp_pin[2], 0);
`endif
    check("byp_3_1", byp_pin[3], 0);

    // short line sets sticky error, err_clr clears it
    drive_frame(1);
    check("short_err", int'(err_geom), 1);
    repeat (5) tick();
    check("short_err_hold", int'(err_geom), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("err_cleared", int'(err_geom), 0);
    check("fcnt_4", int'(frame_cnt), 4);

    // reset mid-frame with a pending config
    in_vsync = 1'b1;
    tick();
    tick();
    drive_line(W, 0);
    drive_line(W, 1);
    cfg_request(1'b0, 2'd1);
    ack_seen = 0;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("midrst");
    rst_n = 1'b1;
    tick();
    drive_line(W, 0);
    drive_line(W - 3, 1);
    in_vsync = 1'b0;
    repeat (3) tick();
    check("partial_err", int'(err_geom), 0);
    check("partial_fcnt", int'(frame_cnt), 0);
    check("partial_busy", int'(cfg_busy), 0);
    drive_frame(-1);
    check("no_ack_after_rst", int'(ack_seen), 0);
    check("post_rst_fcnt", int'(frame_cnt), 1);
    check("post_rst_err", int'(err_geom), 0);
    check("post_rst_en", int'(sharpen_en), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
